// File: rtl/loop_pc_sequencer_pkg.sv
// Shared types and constants for the next-PC sequencer and its hardware-loop counters.
// Field positions describe where jalfor operands sit in the instruction word.
package loop_pc_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOOP = 1'b1
    } seq_state_t;

    localparam int PC_INCR = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int NR_MSB   = 23;
    localparam int NR_LSB   = 20;
    localparam int NECL_MSB = 19;
    localparam int NECL_LSB = 16;
    localparam int TGT_MSB  = 15;
    localparam int TGT_LSB  = 0;

endpackage

// File: rtl/loop_pc_sequencer_counter_pair.sv
// Repeat and body counters for the jalfor hardware loop.
// The body length is captured on load so each new repetition can restart the body count.
module loop_counter_pair
    import loop_pc_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             reload,
    input  logic             dec,
    input  logic             clear,
    input  logic [CNT_W-1:0] nr,
    input  logic [CNT_W-1:0] necl,
    output logic [CNT_W-1:0] iter_left,
    output logic [CNT_W-1:0] body_left,
    output logic             last_body,
    output logic             last_iter
);

    logic [CNT_W-1:0] necl_sv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_left <= '0;
            body_left <= '0;
            necl_sv   <= '0;
        end else if (load) begin
            iter_left <= nr;
            body_left <= necl;
            necl_sv   <= necl;
        end else if (reload) begin
            iter_left <= iter_left - CNT_W'(1);
            body_left <= necl_sv;
        end else if (clear) begin
            iter_left <= '0;
            body_left <= '0;
        end else if (dec) begin
            body_left <= body_left - CNT_W'(1);
        end
    end

    assign last_body = (body_left == CNT_W'(1));
    assign last_iter = (iter_left == CNT_W'(1));

endmodule

// File: rtl/loop_pc_sequencer.sv
// Next-PC stage: owns the PC register, picks sequential/branch/jump/loop targets
// and sequences the jalfor repeat loop with registered one-cycle status pulses.
module loop_pc_sequencer
    import loop_pc_sequencer_pkg::*;
#(
    parameter int               PC_W     = 32,
    parameter int               CNT_W    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             jalfor,
    input  logic [CNT_W-1:0] jalfor_nr,
    input  logic [CNT_W-1:0] jalfor_necl,
    input  logic [PC_W-1:0]  jalfor_target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic             loop_active,
    output logic [CNT_W-1:0] iter_left,
    output logic [CNT_W-1:0] body_left,
    output logic             loop_wrap,
    output logic             loop_exit,
    output logic             nest_err
);

    seq_state_t      state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] ret_q, tgt_q;
    logic            save;
    logic            ctr_load, ctr_reload, ctr_dec, ctr_clear;
    logic            last_body, last_iter;
    logic            wrap_next, exit_next, nest_next;

    assign pc_plus4    = pc + PC_W'(PC_INCR);
    assign loop_active = (state == LOOP);

    loop_counter_pair #(
        .CNT_W (CNT_W)
    ) u_counters (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .reload    (ctr_reload),
        .dec       (ctr_dec),
        .clear     (ctr_clear),
        .nr        (jalfor_nr),
        .necl      (jalfor_necl),
        .iter_left (iter_left),
        .body_left (body_left),
        .last_body (last_body),
        .last_iter (last_iter)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ret_q     <= '0;
            tgt_q     <= '0;
            loop_wrap <= 1'b0;
            loop_exit <= 1'b0;
            nest_err  <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            loop_wrap <= wrap_next;
            loop_exit <= exit_next;
            nest_err  <= nest_next;
            if (save) begin
                ret_q <= pc_plus4;
                tgt_q <= jalfor_target;
            end
        end
    end

    // On the last body slot loop control takes precedence over every decoded redirect.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        save       = 1'b0;
        ctr_load   = 1'b0;
        ctr_reload = 1'b0;
        ctr_dec    = 1'b0;
        ctr_clear  = 1'b0;
        wrap_next  = 1'b0;
        exit_next  = 1'b0;
        nest_next  = 1'b0;
        if (en) begin
            pc_next = pc_plus4;
            case (state)
                IDLE: begin
                    if (jalfor) begin
                        if ((jalfor_nr != '0) && (jalfor_necl != '0)) begin
                            save       = 1'b1;
                            ctr_load   = 1'b1;
                            pc_next    = jalfor_target;
                            state_next = LOOP;
                        end
                    end else if (jump) begin
                        pc_next = jump_target;
                    end else if (branch_taken) begin
                        pc_next = branch_target;
                    end
                end
                LOOP: begin
                    if (last_body) begin
                        if (!last_iter) begin
                            pc_next    = tgt_q;
                            ctr_reload = 1'b1;
                            wrap_next  = 1'b1;
                        end else begin
                            pc_next    = ret_q;
                            ctr_clear  = 1'b1;
                            exit_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        ctr_dec = 1'b1;
                        if (jalfor) begin
                            nest_next = 1'b1;
                        end else if (jump) begin
                            pc_next = jump_target;
                        end else if (branch_taken) begin
                            pc_next = branch_target;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_pc_sequencer.sv
// Directed bench for loop_pc_sequencer: stimulus pushes hand-computed expectations,
// a monitor pops and compares them after each clock edge or asynchronous event.
module tb_loop_pc_sequencer;
    import loop_pc_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jalfor;
    logic [3:0]  jalfor_nr;
    logic [3:0]  jalfor_necl;
    logic [31:0] jalfor_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        loop_active;
    logic [3:0]  iter_left;
    logic [3:0]  body_left;
    logic        loop_wrap;
    logic        loop_exit;
    logic        nest_err;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        act;
        logic [3:0]  iter;
        logic [3:0]  body;
        logic        wrap;
        logic        exit_p;
        logic        nest;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   errors = 0;
    int   checks = 0;

    loop_pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jalfor        (jalfor),
        .jalfor_nr     (jalfor_nr),
        .jalfor_necl   (jalfor_necl),
        .jalfor_target (jalfor_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .loop_active   (loop_active),
        .iter_left     (iter_left),
        .body_left     (body_left),
        .loop_wrap     (loop_wrap),
        .loop_exit     (loop_exit),
        .nest_err      (nest_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkJalfor(input logic [3:0] nr, input logic [3:0] necl,
                                             input logic [15:0] tgt);
        return {8'h00, nr, necl, tgt};
    endfunction

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, act, want);
        end
    endtask

    function automatic exp_t mkExp(input string name, input logic [31:0] e_pc, input logic e_act,
                                   input logic [3:0] e_iter, input logic [3:0] e_body,
                                   input logic e_wrap, input logic e_exit, input logic e_nest);
        exp_t e;
        e.name = name; e.pc = e_pc; e.act = e_act; e.iter = e_iter; e.body = e_body;
        e.wrap = e_wrap; e.exit_p = e_exit; e.nest = e_nest;
        return e;
    endfunction

    // Instruction operands are sliced out with the shared field positions.
    task automatic applyStimulus(input string name, input logic en_v,
                                 input logic br_v, input logic [31:0] brt_v,
                                 input logic j_v, input logic [31:0] jt_v,
                                 input logic jf_v, input logic [31:0] instr,
                                 input logic [31:0] e_pc, input logic e_act,
                                 input logic [3:0] e_iter, input logic [3:0] e_body,
                                 input logic e_wrap, input logic e_exit, input logic e_nest);
        en            = en_v;
        branch_taken  = br_v;
        branch_target = brt_v;
        jump          = j_v;
        jump_target   = jt_v;
        jalfor        = jf_v;
        jalfor_nr     = instr[NR_MSB:NR_LSB];
        jalfor_necl   = instr[NECL_MSB:NECL_LSB];
        jalfor_target = {16'h0000, instr[TGT_MSB:TGT_LSB]};
        exp_q.push_back(mkExp(name, e_pc, e_act, e_iter, e_body, e_wrap, e_exit, e_nest));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every clock edge (or async check event) with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e.name, "pc",          pc,          e.pc);
                checkOutput(e.name, "pc_plus4",    pc_plus4,    e.pc + 32'd4);
                checkOutput(e.name, "loop_active", {31'd0, loop_active}, {31'd0, e.act});
                checkOutput(e.name, "iter_left",   {28'd0, iter_left},   {28'd0, e.iter});
                checkOutput(e.name, "body_left",   {28'd0, body_left},   {28'd0, e.body});
                checkOutput(e.name, "loop_wrap",   {31'd0, loop_wrap},   {31'd0, e.wrap});
                checkOutput(e.name, "loop_exit",   {31'd0, loop_exit},   {31'd0, e.exit_p});
                checkOutput(e.name, "nest_err",    {31'd0, nest_err},    {31'd0, e.nest});
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; jalfor = 1'b0; jalfor_nr = '0;
        jalfor_necl = '0; jalfor_target = '0;
        #2;
        exp_q.push_back(mkExp("reset", 32'h0, 0, 0, 0, 0, 0, 0));
        -> sample_ev;
        @(negedge clk);
        rst_n = 1'b1;

        // name, en, br, brt, j, jt, jf, instr, exp pc, act, iter, body, wrap, exit, nest
        applyStimulus("seq0",      1, 0, 0, 0, 0, 0, 0,                       32'h04, 0, 0, 0, 0, 0, 0);
        applyStimulus("seq1",      1, 0, 0, 0, 0, 0, 0,                       32'h08, 0, 0, 0, 0, 0, 0);
        applyStimulus("jf_start",  1, 0, 0, 0, 0, 1, mkJalfor(2, 3, 16'h14),  32'h14, 1, 2, 3, 0, 0, 0);
        applyStimulus("body_a1",   1, 0, 0, 0, 0, 0, 0,                       32'h18, 1, 2, 2, 0, 0, 0);
        applyStimulus("body_a2",   1, 0, 0, 0, 0, 0, 0,                       32'h1C, 1, 2, 1, 0, 0, 0);
        applyStimulus("wrap_a",    1, 0, 0, 0, 0, 0, 0,                       32'h14, 1, 1, 3, 1, 0, 0);
        applyStimulus("body_a3",   1, 0, 0, 0, 0, 0, 0,                       32'h18, 1, 1, 2, 0, 0, 0);
        applyStimulus("body_a4",   1, 0, 0, 0, 0, 0, 0,                       32'h1C, 1, 1, 1, 0, 0, 0);
        applyStimulus("exit_a",    1, 0, 0, 0, 0, 0, 0,                       32'h0C, 0, 0, 0, 0, 1, 0);
        applyStimulus("post_a",    1, 0, 0, 0, 0, 0, 0,                       32'h10, 0, 0, 0, 0, 0, 0);
        applyStimulus("nr_zero",   1, 0, 0, 0, 0, 1, mkJalfor(0, 5, 16'h80),  32'h14, 0, 0, 0, 0, 0, 0);
        applyStimulus("necl_zero", 1, 0, 0, 1, 32'h300, 1, mkJalfor(3, 0, 16'h80), 32'h18, 0, 0, 0, 0, 0, 0);
        applyStimulus("jump_pri",  1, 1, 32'h500, 1, 32'h100, 0, 0,           32'h100, 0, 0, 0, 0, 0, 0);
        applyStimulus("branch",    1, 1, 32'h200, 0, 0, 0, 0,                 32'h200, 0, 0, 0, 0, 0, 0);
        applyStimulus("jf_b",      1, 0, 0, 0, 0, 1, mkJalfor(2, 3, 16'h40),  32'h40, 1, 2, 3, 0, 0, 0);
        applyStimulus("nested",    1, 0, 0, 0, 0, 1, mkJalfor(5, 5, 16'h80),  32'h44, 1, 2, 2, 0, 0, 1);
        applyStimulus("body_b2",   1, 0, 0, 0, 0, 0, 0,                       32'h48, 1, 2, 1, 0, 0, 0);
        applyStimulus("override",  1, 1, 32'h999, 1, 32'h777, 1, mkJalfor(1, 1, 16'h90), 32'h40, 1, 1, 3, 1, 0, 0);
        applyStimulus("body_b3",   1, 0, 0, 0, 0, 0, 0,                       32'h44, 1, 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall",  0, 1, 32'h999, 1, 32'h777, 0, 0,          32'h44, 1, 1, 2, 0, 0, 0);
        applyStimulus("resume",    1, 0, 0, 0, 0, 0, 0,                       32'h48, 1, 1, 1, 0, 0, 0);
        applyStimulus("exit_b",    1, 0, 0, 0, 0, 0, 0,                       32'h204, 0, 0, 0, 0, 1, 0);
        applyStimulus("stall_ex",  0, 0, 0, 0, 0, 0, 0,                       32'h204, 0, 0, 0, 0, 0, 0);
        applyStimulus("jf_c",      1, 0, 0, 0, 0, 1, mkJalfor(1, 3, 16'h20),  32'h20, 1, 1, 3, 0, 0, 0);
        applyStimulus("br_body",   1, 1, 32'h40, 0, 0, 0, 0,                  32'h40, 1, 1, 2, 0, 0, 0);
        applyStimulus("body_c2",   1, 0, 0, 0, 0, 0, 0,                       32'h44, 1, 1, 1, 0, 0, 0);
        applyStimulus("exit_c",    1, 0, 0, 0, 0, 0, 0,                       32'h208, 0, 0, 0, 0, 1, 0);
        applyStimulus("jf_d",      1, 0, 0, 0, 0, 1, mkJalfor(2, 3, 16'h10),  32'h10, 1, 2, 3, 0, 0, 0);
        applyStimulus("body_d1",   1, 0, 0, 0, 0, 0, 0,                       32'h14, 1, 2, 2, 0, 0, 0);
        applyStimulus("body_d2",   1, 0, 0, 0, 0, 0, 0,                       32'h18, 1, 2, 1, 0, 0, 0);

        #2;
        rst_n = 1'b0;
        exp_q.push_back(mkExp("async_rst", 32'h0, 0, 0, 0, 0, 0, 0));
        -> sample_ev;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("after_rst1", 1, 0, 0, 0, 0, 0, 0,                      32'h04, 0, 0, 0, 0, 0, 0);
        applyStimulus("after_rst2", 1, 0, 0, 0, 0, 0, 0,                      32'h08, 0, 0, 0, 0, 0, 0);
        applyStimulus("jump_top",  1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0,           32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        applyStimulus("pc_wrap",   1, 0, 0, 0, 0, 0, 0,                       32'h0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
